imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Sequences the synchronous instruction memory for the multicycle RISC-V core.
- Owns the PC and the instruction register (IR).
- Handshakes with the main control FSM: fetch_req in, instr_valid out.
- Drives the memory's active-low enable and byte address, waits the memory read latency, captures the word, advances the PC.
- Handles branch/jump redirects and flags out-of-range fetches.

Parameters:
- XLEN, 32, datapath/address width.
- IMEM_DEPTH, 32, instruction memory size in words; valid word index 0..IMEM_DEPTH-1.
- RESET_PC, 0, PC value after reset.
- MEM_LAT, 1, cycles from the sampled enable edge until mem_instr is stable; minimum 1.

Ports:
- clk  in  1  core clock, all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  control FSM requests the next instruction; level, sampled in IDLE only.
- stall  in  1  blocks acceptance of fetch_req.
- pc_load  in  1  redirect strobe.
- pc_next  in  XLEN  redirect target.
- mem_sel  out  1  instruction memory enable, active-low (0 = read).
- mem_addr  out  XLEN  byte address to memory.
- mem_instr  in  32  memory read data.
- ir  out  32  instruction register.
- pc  out  XLEN  next fetch address.
- pc_of_ir  out  XLEN  address of the instruction held in ir.
- instr_valid  out  1  one-cycle pulse when ir has been updated.
- busy  out  1  high in ISSUE and WAIT.
- fetch_fault  out  1  sticky out-of-range/misaligned fetch flag.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, mem_sel=1, mem_addr=0, pc=RESET_PC, pc_of_ir=RESET_PC.
  - ir=32'h00000013 (NOP), instr_valid=0, busy=0, fetch_fault=0.
  - Pending redirect and latency counter cleared.
  - Reset mid-fetch abandons the fetch; no instr_valid is produced.
- States: IDLE, ISSUE, WAIT, DONE, FAULT.
- IDLE:
  - Effective address ea = pc_load ? pc_next : pc; if pc_load, pc<=pc_next.
  - If fetch_req & !stall:
    - ea[XLEN-1:2] >= IMEM_DEPTH -> FAULT.
    - Otherwise latch fetch_addr=ea -> ISSUE.
  - If stall, fetch_req is ignored.
- ISSUE (1 cycle):
  - mem_sel=0, mem_addr={fetch_addr[XLEN-1:2],2'b00}, busy=1.
  - Load latency counter with MEM_LAT -> WAIT.
- WAIT (MEM_LAT cycles):
  - mem_sel=1, mem_addr held, busy=1; counter decrements each cycle.
  - At the edge where the counter reaches 1:
    - ir<=mem_instr, pc_of_ir<=fetch_addr.
    - pc<=pending redirect if one was recorded, else fetch_addr+4 (modulo 2^XLEN) -> DONE.
- DONE (1 cycle):
  - instr_valid=1.
  - pc_load here updates pc.
  - Next state IDLE; fetch_req is not accepted in DONE.
- Fetch timing: fetch_req accepted at edge e0 -> instr_valid high in cycle MEM_LAT+2 after e0 (cycle 3 for MEM_LAT=1). Back-to-back fetch period is MEM_LAT+3 cycles.
- pc_load while busy:
  - Recorded as pending (last value wins); the in-flight instruction is still delivered.
  - The redirect replaces pc+4 at the capture edge.
- FAULT:
  - fetch_fault=1, mem_sel=1, ir/pc_of_ir unchanged, no instr_valid.
  - Leaves to IDLE only on pc_load; pc<=pc_next and fetch_fault clears at that edge.
  - fetch_req is ignored in FAULT.
- Wrap-around: pc+4 from 32'hFFFFFFFC gives 0. The next fetch then checks range normally.
- mem_sel is never 0 outside ISSUE.

Optional Feature:
- Macro IMEM_MISALIGN_CHECK_EN.
- Defined: in IDLE, ea[1:0]!=0 also routes to FAULT, checked alongside the range check.
- Undefined: ea[1:0] ignored; mem_addr word-aligned, pc_of_ir keeps the unaligned value, pc advances by 4 from it.

Decomposition:
- Shared package riscv_core_pkg holds:
  - fetch FSM state encoding;
  - NOP_INSTR constant 32'h00000013;
  - XLEN default;
  - instruction-width constant 32.
- No sub-module; the latency counter is a local register inside the block.

Test Plan:
- Reset, then fetch_req=1 one cycle at pc=0, memory word0=32'h00500093 -> mem_sel=0 for exactly one cycle; instr_valid in cycle 3; ir=32'h00500093; pc_of_ir=0; pc=4.
- Four consecutive fetches -> ir sequence words 0..3, pc_of_ir 0,4,8,12; instr_valid pulses 4 cycles apart with MEM_LAT=1.
- pc_load=1, pc_next=32'h40 during WAIT of fetch at pc=8 -> ir=word2, pc_of_ir=8, then pc=32'h40; next fetch reads word 16.
- pc=IMEM_DEPTH*4=128, fetch_req -> fetch_fault=1, mem_sel stays 1, no instr_valid; pc_load pc_next=0 clears the fault and the next fetch works.
- Assert reset during WAIT -> outputs immediately at reset values (ir=NOP, pc=RESET_PC); no instr_valid afterwards.
- With IMEM_MISALIGN_CHECK_EN defined: pc_load pc_next=32'h6 then fetch_req -> fetch_fault=1. Without the macro: mem_addr=32'h4, pc_of_ir=32'h6, pc=32'hA.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared definitions for the multicycle RISC-V core: fetch FSM encoding,
// widths and the NOP instruction used as the reset value of the IR.
package riscv_core_pkg;

   localparam int XLEN_DEF = 32;
   localparam int INSTR_W  = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [2:0] {
      F_IDLE  = 3'd0,
      F_ISSUE = 3'd1,
      F_WAIT  = 3'd2,
      F_DONE  = 3'd3,
      F_FAULT = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns PC and IR, drives the synchronous IMEM.
// Optional macro IMEM_MISALIGN_CHECK_EN routes misaligned fetch addresses to FAULT.
module imem_fetch_ctrl
   import riscv_core_pkg::*;
#(
   parameter int                XLEN       = XLEN_DEF,
   parameter int                IMEM_DEPTH = 32,
   parameter logic [XLEN-1:0]   RESET_PC   = {XLEN{1'b0}},
   parameter int                MEM_LAT    = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_req,
   input  logic               stall,
   input  logic               pc_load,
   input  logic [XLEN-1:0]    pc_next,
   output logic               mem_sel,
   output logic [XLEN-1:0]    mem_addr,
   input  logic [INSTR_W-1:0] mem_instr,
   output logic [INSTR_W-1:0] ir,
   output logic [XLEN-1:0]    pc,
   output logic [XLEN-1:0]    pc_of_ir,
   output logic               instr_valid,
   output logic               busy,
   output logic               fetch_fault
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(1'b1);
   localparam logic [XLEN-1:0]  WORD_BYTES = XLEN'(3'd4);
   localparam logic [XLEN-3:0]  DEPTH_W = (XLEN-2)'(IMEM_DEPTH);

   fetch_state_e         state_r, state_s;
   logic [XLEN-1:0]      fetch_addr_r, fetch_addr_s;
   logic                 pend_valid_r, pend_valid_s;
   logic [XLEN-1:0]      pend_addr_r, pend_addr_s;
   logic [CNT_W-1:0]     lat_cnt_r, lat_cnt_s;
   logic                 mem_sel_s, instr_valid_s, busy_s, fetch_fault_s;
   logic [XLEN-1:0]      mem_addr_s, pc_s, pc_of_ir_s;
   logic [INSTR_W-1:0]   ir_s;
   logic [XLEN-1:0]      ea_s;
   logic                 ea_bad_s;
   logic [XLEN-1:0]      redir_tgt_s;
   logic                 redir_s;

   assign ea_s = pc_load ? pc_next : pc;
`ifdef IMEM_MISALIGN_CHECK_EN
   assign ea_bad_s = (ea_s[XLEN-1:2] >= DEPTH_W) || (ea_s[1:0] != 2'b00);
`else
   assign ea_bad_s = (ea_s[XLEN-1:2] >= DEPTH_W);
`endif
   // A redirect arriving on the capture edge itself wins over an older pending one
   assign redir_s     = pc_load | pend_valid_r;
   assign redir_tgt_s = pc_load ? pc_next : pend_addr_r;

   // Next-state and next-output logic
   always_comb begin
      state_s       = state_r;
      fetch_addr_s  = fetch_addr_r;
      pend_valid_s  = pend_valid_r;
      pend_addr_s   = pend_addr_r;
      lat_cnt_s     = lat_cnt_r;
      mem_sel_s     = 1'b1;
      mem_addr_s    = mem_addr;
      ir_s          = ir;
      pc_s          = pc;
      pc_of_ir_s    = pc_of_ir;
      instr_valid_s = 1'b0;
      busy_s        = 1'b0;
      fetch_fault_s = fetch_fault;
      case (state_r)
         F_IDLE: begin
            if (pc_load) begin
               pc_s = pc_next;
            end else begin
               pc_s = pc;
            end
            if (fetch_req && !stall) begin
               if (ea_bad_s) begin
                  state_s       = F_FAULT;
                  fetch_fault_s = 1'b1;
               end else begin
                  state_s      = F_ISSUE;
                  fetch_addr_s = ea_s;
                  mem_sel_s    = 1'b0;
                  mem_addr_s   = {ea_s[XLEN-1:2], 2'b00};
                  busy_s       = 1'b1;
               end
            end else begin
               state_s = F_IDLE;
            end
         end
         F_ISSUE: begin
            busy_s    = 1'b1;
            lat_cnt_s = LAT_LOAD;
            state_s   = F_WAIT;
            if (pc_load) begin
               pend_valid_s = 1'b1;
               pend_addr_s  = pc_next;
            end else begin
               pend_valid_s = pend_valid_r;
            end
         end
         F_WAIT: begin
            if (lat_cnt_r == LAT_LAST) begin
               ir_s          = mem_instr;
               pc_of_ir_s    = fetch_addr_r;
               pc_s          = redir_s ? redir_tgt_s : (fetch_addr_r + WORD_BYTES);
               pend_valid_s  = 1'b0;
               instr_valid_s = 1'b1;
               state_s       = F_DONE;
            end else begin
               busy_s    = 1'b1;
               lat_cnt_s = lat_cnt_r - LAT_LAST;
               if (pc_load) begin
                  pend_valid_s = 1'b1;
                  pend_addr_s  = pc_next;
               end else begin
                  pend_valid_s = pend_valid_r;
               end
            end
         end
         F_DONE: begin
            if (pc_load) begin
               pc_s = pc_next;
            end else begin
               pc_s = pc;
            end
            state_s = F_IDLE;
         end
         F_FAULT: begin
            if (pc_load) begin
               pc_s          = pc_next;
               fetch_fault_s = 1'b0;
               state_s       = F_IDLE;
            end else begin
               state_s = F_FAULT;
            end
         end
         default: begin
            state_s = F_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= F_IDLE;
         fetch_addr_r <= RESET_PC;
         pend_valid_r <= 1'b0;
         pend_addr_r  <= {XLEN{1'b0}};
         lat_cnt_r    <= {CNT_W{1'b0}};
         mem_sel      <= 1'b1;
         mem_addr     <= {XLEN{1'b0}};
         ir           <= NOP_INSTR;
         pc           <= RESET_PC;
         pc_of_ir     <= RESET_PC;
         instr_valid  <= 1'b0;
         busy         <= 1'b0;
         fetch_fault  <= 1'b0;
      end else begin
         state_r      <= state_s;
         fetch_addr_r <= fetch_addr_s;
         pend_valid_r <= pend_valid_s;
         pend_addr_r  <= pend_addr_s;
         lat_cnt_r    <= lat_cnt_s;
         mem_sel      <= mem_sel_s;
         mem_addr     <= mem_addr_s;
         ir           <= ir_s;
         pc           <= pc_s;
         pc_of_ir     <= pc_of_ir_s;
         instr_valid  <= instr_valid_s;
         busy         <= busy_s;
         fetch_fault  <= fetch_fault_s;
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl (MEM_LAT=1, IMEM_DEPTH=32).
// Honors IMEM_MISALIGN_CHECK_EN when it is defined for the build.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset, fetch_req, stall, pc_load;
   logic [31:0] pc_next, mem_addr, mem_instr, ir, pc, pc_of_ir;
   logic        mem_sel, instr_valid, busy, fetch_fault;

   logic [31:0] mem [0:31];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          last_pulse;
   int          issue_cnt;
   logic [31:0] issue_addr;

   imem_fetch_ctrl #(
      .XLEN(32), .IMEM_DEPTH(32), .RESET_PC(32'h0), .MEM_LAT(1)
   ) dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .stall(stall),
      .pc_load(pc_load), .pc_next(pc_next), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_instr(mem_instr), .ir(ir), .pc(pc),
      .pc_of_ir(pc_of_ir), .instr_valid(instr_valid), .busy(busy),
      .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory with one cycle of read latency
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_sel == 1'b0) mem_instr <= mem[mem_addr[6:2]];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_pc(input logic [31:0] v);
      @(negedge clk); pc_load = 1'b1; pc_next = v;
      @(negedge clk); pc_load = 1'b0;
   endtask

   // redir: 0 none, 1 pc_load during ISSUE (pending), 2 pc_load during WAIT
   task automatic do_fetch(input string tag, input logic [31:0] e_ir, input logic [31:0] e_pcir,
                           input logic [31:0] e_pc, input int redir, input logic [31:0] tgt);
      int n;
      @(negedge clk); fetch_req = 1'b1;
      @(negedge clk); fetch_req = 1'b0;
      n = 1; issue_cnt = 0; issue_addr = 32'hFFFF_FFFF;
      while (instr_valid !== 1'b1 && n < 20) begin
         if (mem_sel === 1'b0) begin issue_cnt++; issue_addr = mem_addr; end
         if (redir != 0 && n == redir) begin pc_load = 1'b1; pc_next = tgt; end
         else pc_load = 1'b0;
         @(negedge clk); n++;
      end
      pc_load = 1'b0;
      last_pulse = cyc;
      check_eq({tag, "_latency"}, 32'(n), 32'd3);
      check_eq({tag, "_sel_cycles"}, 32'(issue_cnt), 32'd1);
      check_eq({tag, "_ir"}, ir, e_ir);
      check_eq({tag, "_pc_of_ir"}, pc_of_ir, e_pcir);
      check_eq({tag, "_pc"}, pc, e_pc);
   endtask

   task automatic watch_quiet(input string tag, input int ncyc);
      int s0 = 0, v = 0, b = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (mem_sel !== 1'b1) s0++;
         if (instr_valid !== 1'b0) v++;
         if (busy !== 1'b0) b++;
      end
      check_eq({tag, "_sel_low"}, 32'(s0), 32'd0);
      check_eq({tag, "_valid"}, 32'(v), 32'd0);
      check_eq({tag, "_busy"}, 32'(b), 32'd0);
   endtask

   logic [31:0] exp_w [0:3] = '{32'h00500093, 32'h10000001, 32'h10000002, 32'h10000003};

   initial begin
      int prev;
      reset = 1'b1; fetch_req = 1'b0; stall = 1'b0; pc_load = 1'b0; pc_next = 32'h0;
      mem_instr = 32'h0;
      mem[0] = 32'h00500093;
      for (int i = 1; i < 32; i++) mem[i] = 32'h10000000 | 32'(i);
      #1;
      check_eq("rst_mem_sel", {31'd0, mem_sel}, 32'd1);
      check_eq("rst_mem_addr", mem_addr, 32'h0);
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_pc_of_ir", pc_of_ir, 32'h0);
      check_eq("rst_ir", ir, 32'h00000013);
      check_eq("rst_flags", {29'd0, instr_valid, busy, fetch_fault}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      do_fetch("first", 32'h00500093, 32'h0, 32'h4, 0, 32'h0);

      set_pc(32'h0);
      check_eq("setpc0", pc, 32'h0);
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         do_fetch($sformatf("seq%0d", i), exp_w[i], 32'(i * 4), 32'(i * 4 + 4), 0, 32'h0);
         if (i > 0) check_eq($sformatf("seq%0d_period", i), 32'(last_pulse - prev), 32'd4);
         prev = last_pulse;
      end

      set_pc(32'h8);
      do_fetch("redir_wait", 32'h10000002, 32'h8, 32'h40, 2, 32'h40);
      do_fetch("word16", 32'h10000010, 32'h40, 32'h44, 0, 32'h0);
      set_pc(32'h78);
      do_fetch("redir_pend", 32'h1000001E, 32'h78, 32'h7C, 1, 32'h7C);
      do_fetch("last_word", 32'h1000001F, 32'h7C, 32'h80, 0, 32'h0);

      @(negedge clk); fetch_req = 1'b1;
      watch_quiet("range", 4);
      fetch_req = 1'b0;
      check_eq("range_fault", {31'd0, fetch_fault}, 32'd1);
      check_eq("range_ir_kept", ir, 32'h1000001F);
      check_eq("range_pc_kept", pc, 32'h80);
      set_pc(32'h0);
      check_eq("fault_cleared", {31'd0, fetch_fault}, 32'd0);
      do_fetch("after_fault", 32'h00500093, 32'h0, 32'h4, 0, 32'h0);

      @(negedge clk); stall = 1'b1; fetch_req = 1'b1;
      watch_quiet("stall", 3);
      stall = 1'b0; fetch_req = 1'b0;
      check_eq("stall_pc", pc, 32'h4);

      set_pc(32'h6);
`ifdef IMEM_MISALIGN_CHECK_EN
      @(negedge clk); fetch_req = 1'b1;
      watch_quiet("misalign", 3);
      fetch_req = 1'b0;
      check_eq("misalign_fault", {31'd0, fetch_fault}, 32'd1);
      set_pc(32'h0);
`else
      do_fetch("unaligned", 32'h10000001, 32'h6, 32'hA, 0, 32'h0);
      check_eq("unaligned_mem_addr", issue_addr, 32'h4);
`endif

      set_pc(32'h20);
      @(negedge clk); fetch_req = 1'b1;
      @(negedge clk); fetch_req = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check_eq("midrst_ir", ir, 32'h00000013);
      check_eq("midrst_pc", pc, 32'h0);
      check_eq("midrst_pc_of_ir", pc_of_ir, 32'h0);
      check_eq("midrst_flags", {29'd0, instr_valid, busy, mem_sel}, 32'd1);
      @(negedge clk); reset = 1'b0;
      watch_quiet("post_rst", 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
